// File: rtl/uart_sim_transmitter.sv
// UART transmitter for simulation harnesses: bytes arrive over valid/ready, are
// buffered in a small FIFO and serialized 8N1 (or 8N2) LSB-first on txd_o.
// Ports:
//   clk_i    - clock, everything on the rising edge
//   rst_i    - synchronous active-high reset, overrides all other activity
//   data_i   - byte to send, taken on the edge where valid_i && ready_o
//   valid_i  - data_i valid
//   ready_o  - TX FIFO has room
//   txd_o    - serial line, idle high, driven from a flop
//   busy_o   - frame on the wire or bytes still buffered
//   done_o   - one-cycle pulse at the end of each frame's last stop bit

// uart_sim_tx_fifo: first-word-fall-through FIFO holding bytes waiting for the serializer.
// Latency: a word pushed on edge k is visible on pop_dat_o after edge k.
// Backpressure: full_o/empty_o from the registered count; push when full / pop when empty ignored.
module uart_sim_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// uart_sim_transmitter: buffered 8N1/8N2 serializer, LSB first, BIT_T clocks per bit.
// Latency: byte pushed into an empty idle block on edge k drives the start bit after edge k+1.
// Backpressure: ready_o drops while the FIFO is full; back-to-back frames have no idle gap.
module uart_sim_transmitter #(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 19200,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       txd_o,
  output logic       busy_o,
  output logic       done_o
);
  localparam int BIT_T  = CLOCK_FREQ / BAUD_RATE;
  localparam int STOP_T = STOP_BITS * BIT_T;
  // One counter serves both single bits and the whole stop period.
  localparam int CNT_W  = (STOP_T > 2) ? $clog2(STOP_T) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_T - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_T - 1);

  if (BIT_T < 2) begin : g_bad_bit_time
    $fatal(1, "uart_sim_transmitter: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "uart_sim_transmitter: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $fatal(1, "uart_sim_transmitter: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sreg_q, sreg_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dat;

  uart_sim_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (valid_i),
    .push_dat_i (data_i),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sreg_q  <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; txd_d is the line level for the coming cycle, so each
  // transition edge also loads the next bit value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sreg_d   = sreg_q;
    txd_d    = txd_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sreg_d   = fifo_dat;
          txd_d    = 1'b0;
          cnt_d    = BIT_LAST;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          txd_d   = sreg_q[0];
          cnt_d   = BIT_LAST;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          sreg_d = {1'b0, sreg_q[7:1]};
          if (idx_q != 3'd7) begin
            // sreg_q[1] becomes sreg[0] after this shift.
            txd_d = sreg_q[1];
            idx_d = idx_q + 3'd1;
            cnt_d = BIT_LAST;
          end else begin
            txd_d   = 1'b1;
            cnt_d   = STOP_LAST;
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          // Chain straight into the next start bit when more bytes are queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sreg_d   = fifo_dat;
            txd_d    = 1'b0;
            cnt_d    = BIT_LAST;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Outputs: txd/done straight from flops, ready/busy decoded from registered state.
  always_comb begin
    ready_o = !fifo_full;
    busy_o  = (state_q != S_IDLE) || !fifo_empty;
    txd_o   = txd_q;
    done_o  = done_q;
  end
endmodule
